// File: rtl/sync_load_pkg.sv
// sync_load_pkg: shared types and constants for the synchronising-register load arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, register data width, hold-off counter width.
package sync_load_pkg;

  localparam int SYNC_W = 24;  // width of the shared fd1e register bank
  localparam int HOLD_W = 4;   // hold-off counter width, covers HOLD_CYC 0..15

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/sync_load_arb_if.sv
// sync_load_arb_if: bundle between the requesting sub-units and the load arbiter.
// Latency: n/a (wires only).
// Backpressure: req is a level held until its one-cycle ack.
// Signals: req/din from requesters; ack/ld/d/busy/gnt_id from the arbiter.
// master = requester side, slave = arbiter side.
interface sync_load_arb_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 3
);
  import sync_load_pkg::*;

  logic [NREQ-1:0]        req;
  logic [NREQ*SYNC_W-1:0] din;
  logic [NREQ-1:0]        ack;
  logic                   ld;
  logic [SYNC_W-1:0]      d;
  logic                   busy;
  logic [IDW-1:0]         gnt_id;

  modport master (output req, din, input ack, ld, d, busy, gnt_id);
  modport slave  (input req, din, output ack, ld, d, busy, gnt_id);

endinterface

// File: rtl/sync_rr_pick.sv
// sync_rr_pick: picks the first set request bit searching upward from start, wrapping.
// Latency: purely combinational.
// Backpressure: none; any=0 when no request is set.
// Ports: req (NREQ), start (IDW) in; gnt_oh (one-hot), gnt_idx (binary), any out.
module sync_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 3
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  start,
  output logic [NREQ-1:0] gnt_oh,
  output logic [IDW-1:0]  gnt_idx,
  output logic            any
);

  logic [NREQ-1:0] rot;
  logic [IDW:0]    sum;

  always_comb begin
    // Rotate so that bit 0 of rot is requester 'start'; the doubled copy provides the wrap.
    rot = NREQ'({req, req} >> start);
    sum = '0;
    // Descending scan: the last hit written is the lowest offset from start.
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sum = {1'b0, start} + (IDW+1)'(k);
      end
    end
    if (sum >= (IDW+1)'(NREQ)) begin
      sum = sum - (IDW+1)'(NREQ);
    end
    any     = |req;
    gnt_idx = sum[IDW-1:0];
    gnt_oh  = any ? (NREQ'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/sync_load_arb.sv
// sync_load_arb: owns every write to the shared 24-bit load-enable register bank,
//   granting one requester at a time with a single-cycle ld strobe and a hold-off window.
// Latency: req sampled at edge k -> ld/ack/d registered at edge k, bank captures at k+1.
// Backpressure: requesters hold req until ack; req ignored in LOAD and HOLD (busy=1).
// Ports: clk, reset (async, active-high); bus (slave modport): req/din in, ack/ld/d/busy/gnt_id out.
// Build option SYNC_LOAD_ARB_RR_EN: defined = round-robin with a registered pointer,
//   undefined = fixed priority (lowest index wins), no pointer register.
module sync_load_arb
  import sync_load_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int HOLD_CYC = 2,
  parameter int IDW      = 3
) (
  input  logic              clk,
  input  logic              reset,
  sync_load_arb_if.slave    bus
);

  localparam logic [HOLD_W-1:0] HOLD_INIT = (HOLD_CYC > 0) ? HOLD_W'(HOLD_CYC - 1) : '0;

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic              ld_q, ld_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [SYNC_W-1:0] d_q, d_d;
  logic              busy_q, busy_d;
  logic [IDW-1:0]    gnt_id_q, gnt_id_d;

  logic [IDW-1:0]    pick_start;
  logic [NREQ-1:0]   pick_oh;
  logic [IDW-1:0]    pick_idx;
  logic              pick_any;
  logic [SYNC_W-1:0] pick_dat;

`ifdef SYNC_LOAD_ARB_RR_EN
  logic [IDW-1:0] ptr_q, ptr_d;

  assign pick_start = ptr_q;

  // Pointer moves just past the winner so it has lowest priority on the next search.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == IDLE && pick_any) begin
      ptr_d = (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + IDW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign pick_start = '0;
`endif

  sync_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req     (bus.req),
    .start   (pick_start),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  // Winner data mux, one-hot select with constant slice bases.
  always_comb begin
    pick_dat = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_oh[i]) begin
        pick_dat = bus.din[i*SYNC_W +: SYNC_W];
      end
    end
  end

  // State register; outputs are flops too, so ld drops asynchronously on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ld_q     <= 1'b0;
      ack_q    <= '0;
      d_q      <= '0;
      busy_q   <= 1'b0;
      gnt_id_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ld_q     <= ld_d;
      ack_q    <= ack_d;
      d_q      <= d_d;
      busy_q   <= busy_d;
      gnt_id_q <= gnt_id_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_any) state_d = LOAD;
      end
      LOAD: begin
        if (HOLD_CYC > 0) begin
          state_d = HOLD;
          cnt_d   = HOLD_INIT;
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - HOLD_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs. d is left untouched outside a grant.
  always_comb begin
    ld_d     = 1'b0;
    ack_d    = '0;
    d_d      = d_q;
    busy_d   = busy_q;
    gnt_id_d = gnt_id_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          ld_d     = 1'b1;
          ack_d    = pick_oh;
          d_d      = pick_dat;
          gnt_id_d = pick_idx;
          busy_d   = 1'b1;
        end else begin
          busy_d = 1'b0;
        end
      end
      LOAD:    busy_d = (HOLD_CYC > 0);
      HOLD:    busy_d = (cnt_q != '0);
      default: busy_d = 1'b0;
    endcase
  end

  assign bus.ld     = ld_q;
  assign bus.ack    = ack_q;
  assign bus.d      = d_q;
  assign bus.busy   = busy_q;
  assign bus.gnt_id = gnt_id_q;

endmodule
